// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Ceiling log2, never below 1 so a channel index always has at least one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Rotating priority picker: first requester at or above start, wrapping at NCH-1.
module rr_prio_pick
   import rr_arb_mux_pkg::*;
#(
   parameter int NCH = 4,
   localparam int SELW = clog2_min1(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] start,
   output logic [NCH-1:0]  gnt,
   output logic [SELW-1:0] gnt_idx,
   output logic            any
);

   // Scan NCH slots from start upward; the first set request wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(start) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx[SELW-1:0];
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a single registered valid/ready output stage.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   localparam int SELW = clog2_min1(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  start;
   logic [NCH-1:0]   gnt;
   logic [SELW-1:0]  gnt_idx;
   logic             any;
   logic             load_en;
   logic [WIDTH-1:0] sel_data;
   logic [SELW-1:0]  nxt_ptr;

   assign load_en = !out_valid || out_ready;
   assign start   = (mode == MODE_FIXED) ? '0 : ptr;

   rr_prio_pick #(.NCH(NCH)) u_pick (
      .req     (in_valid),
      .start   (start),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   // Accept strobe; suppressed during reset so no channel believes it was taken.
   assign in_ready = (load_en && !rst) ? gnt : '0;

   // Select the granted word and the pointer slot just past it.
   always_comb begin
      sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      nxt_ptr  = (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
   end

   // Output register, handshake and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            if (mode == MODE_RR) ptr <= nxt_ptr;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance.
module tb_rr_arb_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mode;
   logic [3:0]  in_valid;
   logic [127:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_sel;
   logic        out_ready;

   logic        mode3;
   logic [2:0]  in_valid3;
   logic [23:0] in_data3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic [1:0]  out_sel3;
   logic        out_ready3;

   int tests = 0;
   int errs  = 0;

   always #5 clk = ~clk;

   rr_arb_mux #(.WIDTH(32), .NCH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   rr_arb_mux #(.WIDTH(8), .NCH(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode3),
      .in_valid  (in_valid3),
      .in_data   (in_data3),
      .in_ready  (in_ready3),
      .out_valid (out_valid3),
      .out_data  (out_data3),
      .out_sel   (out_sel3),
      .out_ready (out_ready3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      mode       = 1'b0;
      in_valid   = 4'b0000;
      in_data    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      out_ready  = 1'b1;
      mode3      = 1'b0;
      in_valid3  = 3'b000;
      in_data3   = {8'h12, 8'h11, 8'h10};
      out_ready3 = 1'b1;

      // power-on reset
      #1 rst = 1'b1;
      in_valid = 4'b1111;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_sel", 32'(out_sel), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rr_first_ready", 32'(in_ready), 32'b0001);

      // round-robin rotation, no bubbles
      for (int j = 0; j < 6; j++) begin
         step();
         chk("rr_valid", 32'(out_valid), 32'd1);
         chk("rr_sel", 32'(out_sel), 32'(j % 4));
         chk("rr_data", out_data, 32'hA0 + 32'(j % 4));
         chk("rr_ready", 32'(in_ready), 32'(1 << ((j + 1) % 4)));
      end

      // mid-stream reset while a word is held
      rst = 1'b1;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_data", out_data, 32'd0);
      chk("mrst_sel", 32'(out_sel), 32'd0);
      chk("mrst_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("mrst_ptr0", 32'(in_ready), 32'b0001);
      step();
      chk("mrst_sel0", 32'(out_sel), 32'd0);
      chk("mrst_data0", out_data, 32'hA0);

      // fixed priority: channel 1 starves channel 3
      mode = 1'b1;
      in_valid = 4'b1010;
      #1;
      chk("fp_ready", 32'(in_ready), 32'b0010);
      for (int j = 0; j < 4; j++) begin
         step();
         chk("fp_sel", 32'(out_sel), 32'd1);
         chk("fp_data", out_data, 32'hA1);
      end
      in_valid = 4'b1000;
      #1;
      chk("fp_ready3", 32'(in_ready), 32'b1000);
      step();
      chk("fp_sel3", 32'(out_sel), 32'd3);
      chk("fp_data3", out_data, 32'hA3);

      // back-pressure: hold for 5 cycles, ptr still 1 from the last rr grant
      mode = 1'b0;
      in_valid = 4'b1111;
      out_ready = 1'b0;
      #1;
      chk("bp_ready0", 32'(in_ready), 32'd0);
      for (int j = 0; j < 5; j++) begin
         step();
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_sel", 32'(out_sel), 32'd3);
         chk("bp_data", out_data, 32'hA3);
         chk("bp_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release", 32'(in_ready), 32'b0010);
      step();
      chk("bp_sel1", 32'(out_sel), 32'd1);
      chk("bp_data1", out_data, 32'hA1);

      // drain: single word from channel 2, then idle
      in_valid = 4'b0100;
      #1;
      chk("dr_ready", 32'(in_ready), 32'b0100);
      step();
      in_valid = 4'b0000;
      chk("dr_valid1", 32'(out_valid), 32'd1);
      chk("dr_sel", 32'(out_sel), 32'd2);
      step();
      chk("dr_valid0", 32'(out_valid), 32'd0);
      chk("dr_hold_sel", 32'(out_sel), 32'd2);
      chk("dr_hold_data", out_data, 32'hA2);
      step();
      chk("dr_idle", 32'(out_valid), 32'd0);
      in_valid = 4'b1001;
      #1;
      chk("dr_ptr3", 32'(in_ready), 32'b1000);
      step();
      chk("dr_sel3", 32'(out_sel), 32'd3);
      in_valid = 4'b0000;

      // non-power-of-two channel count
      in_valid3 = 3'b111;
      #1;
      chk("n3_ready", 32'(in_ready3), 32'b001);
      for (int j = 0; j < 5; j++) begin
         step();
         chk("n3_valid", 32'(out_valid3), 32'd1);
         chk("n3_sel", 32'(out_sel3), 32'(j % 3));
         chk("n3_data", 32'(out_data3), 32'h10 + 32'(j % 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
